// File: rtl/cpu_memory_access_pkg.sv
// Shared definitions for the Moxie memory-access stage.
//   PCB_*        : bit positions inside the pipeline control bus from execute
//   mem_size_e   : access size codes carried on mem_size_i
//   state_e      : memory-access FSM states
//   access_bad() : size/alignment legality check for a load or store
package cpu_memory_access_pkg;

  localparam int unsigned PCB_WIDTH = 5;
  localparam int unsigned PCB_WA    = 0;
  localparam int unsigned PCB_WB    = 1;
  localparam int unsigned PCB_RM    = 2;
  localparam int unsigned PCB_WM    = 3;
  localparam int unsigned PCB_LPC   = 4;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE  = 2'd0,
    MEM_SIZE_SHORT = 2'd1,
    MEM_SIZE_LONG  = 2'd2
  } mem_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Size code 3 is undefined and is rejected like a misaligned access.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      MEM_SIZE_BYTE:  bad = 1'b0;
      MEM_SIZE_SHORT: bad = addr_lo[0];
      MEM_SIZE_LONG:  bad = |addr_lo;
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/cpu_mem_lane.sv
// Byte-lane steering for the data-memory port (big-endian, lane 3 = bits 31:24).
//   size_i       in  2   access size code
//   addr_lo_i    in  2   low address bits of the access
//   store_data_i in  32  right-justified store data
//   rdata_i      in  32  raw read data from memory
//   sel_o        out 4   byte-lane enables
//   wdata_o      out 32  store data replicated across all lanes
//   load_data_o  out 32  selected lanes, zero-extended
module cpu_mem_lane
  import cpu_memory_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  always_comb begin
    sel_o       = '0;
    wdata_o     = '0;
    load_data_o = '0;
    case (size_i)
      MEM_SIZE_BYTE: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
        case (addr_lo_i)
          2'd0:    load_data_o = {24'h0, rdata_i[31:24]};
          2'd1:    load_data_o = {24'h0, rdata_i[23:16]};
          2'd2:    load_data_o = {24'h0, rdata_i[15:8]};
          default: load_data_o = {24'h0, rdata_i[7:0]};
        endcase
      end
      MEM_SIZE_SHORT: begin
        sel_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = addr_lo_i[1] ? {16'h0, rdata_i[15:0]} : {16'h0, rdata_i[31:16]};
      end
      MEM_SIZE_LONG: begin
        sel_o       = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_memory_access.sv
// Moxie memory-access stage between execute and writeback.
// Performs the load/store named by the control bits over a req/ack port,
// merges load data into port A, forwards write enables/indices, and stalls
// execute while an access is outstanding.
//   clk_i, rst_i (async, active-low)
//   pipeline_control_bits_i, register*_write_index_i, reg*_result_i,
//   memory_address_i, mem_result_i, mem_size_i, PC_i   : from execute
//   dmem_req_o/we_o/addr_o/sel_o/wdata_o, dmem_ack_i/rdata_i : data memory
//   register_we*_o, register*_write_index_o, reg*_result_o, PC_o : to writeback
//   stall_o, branch_flag_o, branch_target_o, fault_o   : pipeline control
module cpu_memory_access
  import cpu_memory_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [1:0]           mem_size_i,
  input  logic [31:0]          PC_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [31:0]          dmem_addr_o,
  output logic [3:0]           dmem_sel_o,
  output logic [31:0]          dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [31:0]          dmem_rdata_i,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic [31:0]          reg0_result_o,
  output logic [31:0]          reg1_result_o,
  output logic [31:0]          PC_o,
  output logic                 stall_o,
  output logic                 branch_flag_o,
  output logic [31:0]          branch_target_o,
  output logic                 fault_o
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Captured instruction, held for the whole access.
  logic [PCB_WIDTH-1:0] pcb_q, pcb_d;
  logic [3:0]           idx0_q, idx0_d, idx1_q, idx1_d;
  logic [31:0]          r0_q, r0_d, r1_q, r1_d, addr_q, addr_d, sdata_q, sdata_d, pc_q, pc_d;
  logic [1:0]           size_q, size_d;

  // Registered outputs.
  logic                 req_q, req_d, stall_q, stall_d, fault_q, fault_d, bflag_q, bflag_d;
  logic                 wea_q, wea_d, web_q, web_d;
  logic [3:0]           oidx0_q, oidx0_d, oidx1_q, oidx1_d;
  logic [31:0]          ores0_q, ores0_d, ores1_q, ores1_d, opc_q, opc_d, btgt_q, btgt_d;

  logic [3:0]           lane_sel;
  logic [31:0]          lane_wdata, load_data;
  logic                 is_mem, is_bad;

  cpu_mem_lane u_lane (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .store_data_i(sdata_q),
    .rdata_i     (dmem_rdata_i),
    .sel_o       (lane_sel),
    .wdata_o     (lane_wdata),
    .load_data_o (load_data)
  );

  assign is_mem = pipeline_control_bits_i[PCB_RM] | pipeline_control_bits_i[PCB_WM];
  assign is_bad = (pipeline_control_bits_i[PCB_RM] & pipeline_control_bits_i[PCB_WM]) |
                  access_bad(mem_size_i, memory_address_i[1:0]);

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;
    pcb_d   = pcb_q;    idx0_d  = idx0_q;  idx1_d = idx1_q;
    r0_d    = r0_q;     r1_d    = r1_q;    addr_d = addr_q;
    sdata_d = sdata_q;  size_d  = size_q;  pc_d   = pc_q;
    req_d   = req_q;    stall_d = stall_q;
    wea_d   = wea_q;    web_d   = web_q;
    oidx0_d = oidx0_q;  oidx1_d = oidx1_q;
    ores0_d = ores0_q;  ores1_d = ores1_q;
    opc_d   = opc_q;    btgt_d  = btgt_q;
    fault_d = 1'b0;     bflag_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem && !is_bad) begin
          pcb_d   = pipeline_control_bits_i;
          idx0_d  = register0_write_index_i;
          idx1_d  = register1_write_index_i;
          r0_d    = reg0_result_i;
          r1_d    = reg1_result_i;
          addr_d  = memory_address_i;
          sdata_d = mem_result_i;
          size_d  = mem_size_i;
          pc_d    = PC_i;
          wea_d   = 1'b0;
          web_d   = 1'b0;
          req_d   = 1'b1;
          stall_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          // Plain op, or a rejected access forwarded with enables cleared.
          wea_d   = pipeline_control_bits_i[PCB_WA] & ~is_mem;
          web_d   = pipeline_control_bits_i[PCB_WB] & ~is_mem;
          fault_d = is_mem;
          oidx0_d = register0_write_index_i;
          oidx1_d = register1_write_index_i;
          ores0_d = reg0_result_i;
          ores1_d = reg1_result_i;
          opc_d   = PC_i;
        end
      end
      ST_ACCESS: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (dmem_ack_i) begin
          req_d   = 1'b0;
          stall_d = 1'b0;
          state_d = ST_IDLE;
          wea_d   = pcb_q[PCB_WA];
          web_d   = pcb_q[PCB_WB];
          oidx0_d = idx0_q;
          oidx1_d = idx1_q;
          ores0_d = pcb_q[PCB_RM] ? load_data : r0_q;
          ores1_d = r1_q;
          opc_d   = pc_q;
          if (pcb_q[PCB_RM] && pcb_q[PCB_LPC]) begin
            bflag_d = 1'b1;
            btgt_d  = load_data;
          end
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          stall_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;  cnt_q   <= '0;
      pcb_q   <= '0;       idx0_q  <= '0;  idx1_q <= '0;
      r0_q    <= '0;       r1_q    <= '0;  addr_q <= '0;
      sdata_q <= '0;       size_q  <= '0;  pc_q   <= '0;
      req_q   <= 1'b0;     stall_q <= 1'b0;
      wea_q   <= 1'b0;     web_q   <= 1'b0;
      oidx0_q <= '0;       oidx1_q <= '0;
      ores0_q <= '0;       ores1_q <= '0;
      opc_q   <= '0;       btgt_q  <= '0;
      fault_q <= 1'b0;     bflag_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q   <= cnt_d;
      pcb_q   <= pcb_d;    idx0_q  <= idx0_d;  idx1_q <= idx1_d;
      r0_q    <= r0_d;     r1_q    <= r1_d;    addr_q <= addr_d;
      sdata_q <= sdata_d;  size_q  <= size_d;  pc_q   <= pc_d;
      req_q   <= req_d;    stall_q <= stall_d;
      wea_q   <= wea_d;    web_q   <= web_d;
      oidx0_q <= oidx0_d;  oidx1_q <= oidx1_d;
      ores0_q <= ores0_d;  ores1_q <= ores1_d;
      opc_q   <= opc_d;    btgt_q  <= btgt_d;
      fault_q <= fault_d;  bflag_q <= bflag_d;
    end
  end

  // Port fields are forced to zero whenever no request is outstanding.
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = req_q & pcb_q[PCB_WM];
  assign dmem_addr_o  = req_q ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_sel_o   = req_q ? lane_sel : '0;
  assign dmem_wdata_o = req_q ? lane_wdata : '0;

  assign register_wea_o          = wea_q;
  assign register_web_o          = web_q;
  assign register0_write_index_o = oidx0_q;
  assign register1_write_index_o = oidx1_q;
  assign reg0_result_o           = ores0_q;
  assign reg1_result_o           = ores1_q;
  assign PC_o                    = opc_q;
  assign stall_o                 = stall_q;
  assign branch_flag_o           = bflag_q;
  assign branch_target_o         = btgt_q;
  assign fault_o                 = fault_q;

endmodule

// File: tb/tb_cpu_memory_access.sv
module tb_cpu_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  pipeline_control_bits_i;
  logic [3:0]  register0_write_index_i, register1_write_index_i;
  logic [31:0] reg0_result_i, reg1_result_i, memory_address_i, mem_result_i, PC_i;
  logic [1:0]  mem_size_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_sel_o;
  logic        register_wea_o, register_web_o;
  logic [3:0]  register0_write_index_o, register1_write_index_o;
  logic [31:0] reg0_result_o, reg1_result_o, PC_o, branch_target_o;
  logic        stall_o, branch_flag_o, fault_o;

  localparam logic [4:0] WA = 5'b00001, WB = 5'b00010, RM = 5'b00100, WM = 5'b01000, LPC = 5'b10000;

  int n_cmp = 0;
  int n_err = 0;

  cpu_memory_access #(.ACK_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipeline_control_bits_i(pipeline_control_bits_i),
    .register0_write_index_i(register0_write_index_i),
    .register1_write_index_i(register1_write_index_i),
    .reg0_result_i(reg0_result_i), .reg1_result_i(reg1_result_i),
    .memory_address_i(memory_address_i), .mem_result_i(mem_result_i),
    .mem_size_i(mem_size_i), .PC_i(PC_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_sel_o(dmem_sel_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .register_wea_o(register_wea_o), .register_web_o(register_web_o),
    .register0_write_index_o(register0_write_index_o),
    .register1_write_index_o(register1_write_index_o),
    .reg0_result_o(reg0_result_o), .reg1_result_o(reg1_result_o),
    .PC_o(PC_o), .stall_o(stall_o), .branch_flag_o(branch_flag_o),
    .branch_target_o(branch_target_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] pcb, input logic [3:0] i0, input logic [3:0] i1,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [1:0] sz, input logic [31:0] pc);
    pipeline_control_bits_i = pcb;
    register0_write_index_i = i0;
    register1_write_index_i = i1;
    reg0_result_i = r0;  reg1_result_i = r1;
    memory_address_i = addr;  mem_result_i = sd;
    mem_size_i = sz;  PC_i = pc;
  endtask

  task automatic nop();
    drive(5'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Completes an outstanding access with an ack in the current cycle.
  task automatic ack_with(input logic [31:0] data);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = data;
    step();
    dmem_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b0;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = '0;
    drive(WA | RM, 4'h1, 4'h2, 32'h5, 32'h6, 32'h100, 32'h0, 2'd2, 32'h8);
    step(); step();
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_wea", register_wea_o, 0);
    check("rst_res0", reg0_result_o, 0);
    check("rst_fault", fault_o, 0);
    nop();
    rst_i = 1'b1;

    // ADD passthrough
    drive(WA | WB, 4'h3, 4'h7, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 2'd0, 32'h40);
    step();
    check("add_res0", reg0_result_o, 32'h12345678);
    check("add_res1", reg1_result_o, 32'h9ABCDEF0);
    check("add_wea", register_wea_o, 1);
    check("add_web", register_web_o, 1);
    check("add_idx0", register0_write_index_o, 4'h3);
    check("add_pc", PC_o, 32'h40);
    check("add_stall", stall_o, 0);

    // Long load at 0x100, ack in third request cycle
    drive(WA | RM, 4'h5, 4'h0, 32'h11111111, 32'h0, 32'h100, 32'h0, 2'd2, 32'h44);
    step();
    nop();
    check("ld_req1", dmem_req_o, 1);
    check("ld_stall1", stall_o, 1);
    check("ld_addr", dmem_addr_o, 32'h100);
    check("ld_sel", dmem_sel_o, 4'hF);
    check("ld_we", dmem_we_o, 0);
    check("ld_bubble", register_wea_o, 0);
    step();
    check("ld_req2", dmem_req_o, 1);
    step();
    check("ld_req3", dmem_req_o, 1);
    check("ld_stall3", stall_o, 1);
    ack_with(32'hDEADBEEF);
    check("ld_req_off", dmem_req_o, 0);
    check("ld_stall_off", stall_o, 0);
    check("ld_res0", reg0_result_o, 32'hDEADBEEF);
    check("ld_wea", register_wea_o, 1);
    check("ld_idx0", register0_write_index_o, 4'h5);
    check("ld_pc", PC_o, 32'h44);
    check("ld_bflag", branch_flag_o, 0);

    // Byte store 0xAB at 0x203
    drive(WM, 4'h0, 4'h0, 32'h0, 32'h0, 32'h203, 32'h000000AB, 2'd0, 32'h48);
    step();
    nop();
    check("st_addr", dmem_addr_o, 32'h200);
    check("st_sel", dmem_sel_o, 4'b0001);
    check("st_wdata", dmem_wdata_o, 32'hABABABAB);
    check("st_we", dmem_we_o, 1);
    ack_with(32'h0);
    check("st_req_off", dmem_req_o, 0);
    check("st_wea", register_wea_o, 0);

    // Misaligned long load at 0x102
    drive(WA | WB | RM, 4'h2, 4'h3, 32'h0, 32'h0, 32'h102, 32'h0, 2'd2, 32'h4C);
    step();
    nop();
    check("mis_req", dmem_req_o, 0);
    check("mis_fault", fault_o, 1);
    check("mis_wea", register_wea_o, 0);
    check("mis_web", register_web_o, 0);
    check("mis_stall", stall_o, 0);
    step();
    check("mis_fault_pulse", fault_o, 0);

    // RM and WM together
    drive(WA | RM | WM, 4'h2, 4'h0, 32'h0, 32'h0, 32'h100, 32'h0, 2'd2, 32'h50);
    step();
    nop();
    check("rmwm_req", dmem_req_o, 0);
    check("rmwm_fault", fault_o, 1);

    // Short load at 0x102 selects low half
    drive(WA | RM, 4'h6, 4'h0, 32'h0, 32'h0, 32'h102, 32'h0, 2'd1, 32'h54);
    step();
    nop();
    check("sh_sel", dmem_sel_o, 4'b0011);
    ack_with(32'hCAFEBABE);
    check("sh_res0", reg0_result_o, 32'h0000BABE);

    // Byte load at 0x201
    drive(WA | RM, 4'h6, 4'h0, 32'h0, 32'h0, 32'h201, 32'h0, 2'd0, 32'h58);
    step();
    nop();
    check("bl_sel", dmem_sel_o, 4'b0100);
    ack_with(32'h11223344);
    check("bl_res0", reg0_result_o, 32'h00000022);

    // Timeout with no ack
    drive(WA | RM, 4'h1, 4'h0, 32'h0, 32'h0, 32'h300, 32'h0, 2'd2, 32'h5C);
    step();
    nop();
    n = 0;
    while (dmem_req_o && n < 20) begin
      n++;
      step();
    end
    check("to_cycles", n, 8);
    check("to_fault", fault_o, 1);
    check("to_stall", stall_o, 0);
    check("to_wea", register_wea_o, 0);

    // Ack arriving in the last cycle before timeout wins
    drive(WA | RM, 4'h9, 4'h0, 32'h0, 32'h0, 32'h304, 32'h0, 2'd2, 32'h60);
    step();
    nop();
    for (int i = 0; i < 7; i++) step();
    check("aw_req", dmem_req_o, 1);
    ack_with(32'h0BADF00D);
    check("aw_fault", fault_o, 0);
    check("aw_wea", register_wea_o, 1);
    check("aw_res0", reg0_result_o, 32'h0BADF00D);

    // Load of a return address
    drive(WA | RM | LPC, 4'hF, 4'h0, 32'h0, 32'h0, 32'h400, 32'h0, 2'd2, 32'h64);
    step();
    nop();
    ack_with(32'h00001000);
    check("br_flag", branch_flag_o, 1);
    check("br_target", branch_target_o, 32'h1000);
    check("br_wea", register_wea_o, 1);
    check("br_res0", reg0_result_o, 32'h1000);
    step();
    check("br_flag_pulse", branch_flag_o, 0);

    // Reset in the middle of an access; a late ack is ignored
    drive(WA | RM, 4'h4, 4'h0, 32'h0, 32'h0, 32'h500, 32'h0, 2'd2, 32'h68);
    step();
    nop();
    check("mr_req_before", dmem_req_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("mr_req_async", dmem_req_o, 0);
    check("mr_stall_async", stall_o, 0);
    #1 rst_i = 1'b1;
    ack_with(32'hFFFFFFFF);
    check("mr_req_after", dmem_req_o, 0);
    check("mr_wea_after", register_wea_o, 0);
    check("mr_res0_after", reg0_result_o, 32'h0);
    check("mr_stall_after", stall_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
